fetch_decode_unit: RTL and testbench

- Front end of the 9-bit single-cycle core: program counter, 16-entry branch-target lookup table and main instruction decoder in one block.
- Takes the fetched machine word and the lagging "one" flag from the ALU flag register.
- Produces the next instruction address and all datapath control signals for the register file, ALU mux, ALU and data memory.

---
 rtl/fdu_pkg.sv | 65 ++++++
 rtl/fdu_decoder.sv | 60 ++++++
 rtl/fetch_decode_unit.sv | 78 +++++++
 tb/tb_fetch_decode_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fdu_pkg.sv
// fdu_pkg: shared definitions for the fetch/decode front end of the 9-bit core.
//   - opcode encodings for mach_code[8:4]
//   - ALU command enumeration
//   - instruction-type encodings
//   - the decoded control bundle passed from the decoder to the top
//   - default branch-target lookup table contents
package fdu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_LSL    = 4'd5,
    ALU_LSR    = 4'd6,
    ALU_PASS_A = 4'd7,
    ALU_CMP    = 4'd8
  } alu_op_e;

  // Which register field the result is written through.
  localparam logic [1:0] IT_R_RS = 2'b00;
  localparam logic [1:0] IT_R_RT = 2'b01;
  localparam logic [1:0] IT_I    = 2'b10;

  // Top two opcode bits equal to this mark an I-type (load immediate).
  localparam logic [1:0] OPC_ITYPE = 2'b11;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_LSL  = 5'b00101;
  localparam logic [4:0] OP_LSR  = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b00111;
  localparam logic [4:0] OP_MOVR = 5'b01000;
  localparam logic [4:0] OP_LD   = 5'b01001;
  localparam logic [4:0] OP_ST   = 5'b01010;
  localparam logic [4:0] OP_CMP  = 5'b01011;
  localparam logic [4:0] OP_BR   = 5'b01100;

  typedef struct packed {
    logic [1:0] inst_type;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic       is_addi;
    logic       is_movr;
    logic       is_cond;
    alu_op_e    alu_op;
  } ctrl_t;

  // Entry i holds i*16; the top zero-extends to the PC width.
  localparam int unsigned LUT_DEFAULT [16] = '{
    0,   16,  32,  48,  64,  80,  96,  112,
    128, 144, 160, 176, 192, 208, 224, 240
  };

endpackage

// File: rtl/fdu_decoder.sv
// fdu_decoder: purely combinational main decoder.
//   i_op   in  5  opcode field mach_code[8:4]
//   o_ctrl out    decoded datapath controls (all zero for NOP/unknown codes)
module fdu_decoder
  import fdu_pkg::*;
(
  input  logic [4:0] i_op,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl        = '0;
    o_ctrl.alu_op = ALU_ADD;
    if (i_op[4:3] == OPC_ITYPE) begin
      // Load immediate: low opcode bits are part of the immediate, not a sub-op.
      o_ctrl.inst_type = IT_I;
      o_ctrl.reg_write = 1'b1;
    end else begin
      case (i_op)
        OP_ADD: begin o_ctrl.alu_op = ALU_ADD; o_ctrl.reg_write = 1'b1; end
        OP_SUB: begin o_ctrl.alu_op = ALU_SUB; o_ctrl.reg_write = 1'b1; end
        OP_AND: begin o_ctrl.alu_op = ALU_AND; o_ctrl.reg_write = 1'b1; end
        OP_OR:  begin o_ctrl.alu_op = ALU_OR;  o_ctrl.reg_write = 1'b1; end
        OP_XOR: begin o_ctrl.alu_op = ALU_XOR; o_ctrl.reg_write = 1'b1; end
        OP_LSL: begin o_ctrl.alu_op = ALU_LSL; o_ctrl.reg_write = 1'b1; end
        OP_LSR: begin o_ctrl.alu_op = ALU_LSR; o_ctrl.reg_write = 1'b1; end
        OP_ADDI: begin
          o_ctrl.alu_op    = ALU_ADD;
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.is_addi   = 1'b1;
          o_ctrl.reg_write = 1'b1;
        end
        OP_MOVR: begin
          o_ctrl.alu_op    = ALU_PASS_A;
          o_ctrl.inst_type = IT_R_RT;
          o_ctrl.is_movr   = 1'b1;
          o_ctrl.reg_write = 1'b1;
        end
        OP_LD: begin
          o_ctrl.alu_op     = ALU_PASS_A;
          o_ctrl.inst_type  = IT_R_RT;
          o_ctrl.mem_read   = 1'b1;
          o_ctrl.mem_to_reg = 1'b1;
          o_ctrl.reg_write  = 1'b1;
        end
        OP_ST: begin
          o_ctrl.alu_op    = ALU_PASS_A;
          o_ctrl.mem_write = 1'b1;
        end
        OP_CMP: begin
          o_ctrl.alu_op  = ALU_CMP;
          o_ctrl.is_cond = 1'b1;
        end
        OP_BR:   o_ctrl.branch = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: program counter, branch-target LUT and instruction decoder.
//   clk         in  1  rising-edge clock
//   reset       in  1  synchronous reset, active low
//   mach_code   in  9  current instruction word
//   one_flag    in  1  registered ALU "one" flag, branch condition
//   reljump_en  in  1  relative-jump request
//   prog_ctr    out D  current program counter
//   InstType .. ALUOp  decoded datapath controls
//   done        out 1  high while prog_ctr equals DONE_ADDR
module fetch_decode_unit
  import fdu_pkg::*;
#(
  parameter int D         = 12,
  parameter int A         = 4,
  parameter int DONE_ADDR = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [8:0]   mach_code,
  input  logic         one_flag,
  input  logic         reljump_en,
  output logic [D-1:0] prog_ctr,
  output logic [1:0]   InstType,
  output logic         BranchInst,
  output logic         MemRead,
  output logic         MemWrite,
  output logic         MemtoReg,
  output logic         ALUSrc,
  output logic         RegWrite,
  output logic         isaddi,
  output logic         ismovr,
  output logic         iscond,
  output logic [A-1:0] ALUOp,
  output logic         done
);

  logic [D-1:0] r_pc;
  logic [D-1:0] w_lut_target;
  logic         w_abs_jump;
  ctrl_t        w_ctrl;

  fdu_decoder u_decoder (
    .i_op   (mach_code[8:4]),
    .o_ctrl (w_ctrl)
  );

  assign w_lut_target = D'(LUT_DEFAULT[mach_code[3:0]]);
  assign w_abs_jump   = w_ctrl.branch && one_flag;

  // Absolute jump has priority over a relative jump; all sums wrap at 2^D.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= '0;
    end else if (w_abs_jump) begin
      r_pc <= w_lut_target;
    end else if (reljump_en) begin
      r_pc <= r_pc + w_lut_target;
    end else begin
      r_pc <= r_pc + D'(1);
    end
  end

  assign prog_ctr   = r_pc;
  assign done       = (r_pc == D'(DONE_ADDR));

  assign InstType   = w_ctrl.inst_type;
  assign BranchInst = w_ctrl.branch;
  assign MemRead    = w_ctrl.mem_read;
  assign MemWrite   = w_ctrl.mem_write;
  assign MemtoReg   = w_ctrl.mem_to_reg;
  assign ALUSrc     = w_ctrl.alu_src;
  assign RegWrite   = w_ctrl.reg_write;
  assign isaddi     = w_ctrl.is_addi;
  assign ismovr     = w_ctrl.is_movr;
  assign iscond     = w_ctrl.is_cond;
  assign ALUOp      = A'(w_ctrl.alu_op);

endmodule

// File: tb/tb_fetch_decode_unit.sv
module tb_fetch_decode_unit;

  // Expected control bundle: InstType, Branch, MemRead, MemWrite, MemtoReg,
  // ALUSrc, RegWrite, isaddi, ismovr, iscond, ALUOp.
  typedef struct packed {
    logic [1:0] it;
    logic       br;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       asrc;
    logic       rw;
    logic       addi;
    logic       movr;
    logic       cond;
    logic [3:0] op;
  } exp_t;

  typedef struct packed {
    logic [8:0] mc;
    exp_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  mach_code;
  logic        one_flag;
  logic        reljump_en;
  logic [11:0] prog_ctr;
  logic [1:0]  InstType;
  logic        BranchInst, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite;
  logic        isaddi, ismovr, iscond, done;
  logic [3:0]  ALUOp;

  int checks = 0;
  int errors = 0;
  int model_pc = 0;
  exp_t ref_tab [13];
  vec_t vecs [12];

  fetch_decode_unit #(.D(12), .A(4), .DONE_ADDR(65)) dut (
    .clk        (clk),
    .reset      (reset),
    .mach_code  (mach_code),
    .one_flag   (one_flag),
    .reljump_en (reljump_en),
    .prog_ctr   (prog_ctr),
    .InstType   (InstType),
    .BranchInst (BranchInst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .isaddi     (isaddi),
    .ismovr     (ismovr),
    .iscond     (iscond),
    .ALUOp      (ALUOp),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t actual_ctrl();
    return {InstType, BranchInst, MemRead, MemWrite, MemtoReg, ALUSrc,
            RegWrite, isaddi, ismovr, iscond, ALUOp};
  endfunction

  // Reference decode: I-type by top two bits, otherwise a lookup by opcode number.
  function automatic exp_t model_dec(input logic [8:0] mc);
    exp_t e;
    int   opn;
    e   = '0;
    opn = int'(mc[8:4]);
    if (mc[8:7] == 2'b11) begin
      e.it = 2'b10;
      e.rw = 1'b1;
    end else if (opn < 13) begin
      e = ref_tab[opn];
    end
    return e;
  endfunction

  // One clock with the given inputs; checks decode before the edge and PC after.
  task automatic step(input logic [8:0] mc, input logic o, input logic r, input logic rst_n);
    exp_t e;
    int   tgt;
    mach_code  = mc;
    one_flag   = o;
    reljump_en = r;
    reset      = rst_n;
    #1;
    e = model_dec(mc);
    chk("decode", 32'(actual_ctrl()), 32'(e));
    tgt = int'(mc[3:0]) * 16;
    if (!rst_n)           model_pc = 0;
    else if (e.br && o)   model_pc = tgt;
    else if (r)           model_pc = (model_pc + tgt) % 4096;
    else                  model_pc = (model_pc + 1) % 4096;
    @(posedge clk);
    #1;
    chk("prog_ctr", 32'(prog_ctr), 32'(model_pc));
    chk("done", 32'(done), 32'(model_pc == 65));
  endtask

  initial begin
    // Opcode table 00000..01100 in mnemonic order ADD..BR.
    ref_tab[0]  = '{it:2'b00, rw:1'b1, op:4'd0, default:1'b0};
    ref_tab[1]  = '{it:2'b00, rw:1'b1, op:4'd1, default:1'b0};
    ref_tab[2]  = '{it:2'b00, rw:1'b1, op:4'd2, default:1'b0};
    ref_tab[3]  = '{it:2'b00, rw:1'b1, op:4'd3, default:1'b0};
    ref_tab[4]  = '{it:2'b00, rw:1'b1, op:4'd4, default:1'b0};
    ref_tab[5]  = '{it:2'b00, rw:1'b1, op:4'd5, default:1'b0};
    ref_tab[6]  = '{it:2'b00, rw:1'b1, op:4'd6, default:1'b0};
    ref_tab[7]  = '{it:2'b00, rw:1'b1, asrc:1'b1, addi:1'b1, op:4'd0, default:1'b0};
    ref_tab[8]  = '{it:2'b01, rw:1'b1, movr:1'b1, op:4'd7, default:1'b0};
    ref_tab[9]  = '{it:2'b01, rw:1'b1, mr:1'b1, m2r:1'b1, op:4'd7, default:1'b0};
    ref_tab[10] = '{it:2'b00, mw:1'b1, op:4'd7, default:1'b0};
    ref_tab[11] = '{it:2'b00, cond:1'b1, op:4'd8, default:1'b0};
    ref_tab[12] = '{it:2'b00, br:1'b1, op:4'd0, default:1'b0};

    // Hand-written decode vectors: mc, then it br mr mw m2r asrc rw addi movr cond op.
    vecs[0]  = {9'b11_101_0111, 15'b10_0_0_0_0_0_1_0_0_0_0000};
    vecs[1]  = {9'b01001_0101,  15'b01_0_1_0_1_0_1_0_0_0_0111};
    vecs[2]  = {9'b00111_0010,  15'b00_0_0_0_0_1_1_1_0_0_0000};
    vecs[3]  = {9'b01110_0000,  15'b00_0_0_0_0_0_0_0_0_0_0000};
    vecs[4]  = {9'b00001_1111,  15'b00_0_0_0_0_0_1_0_0_0_0001};
    vecs[5]  = {9'b01000_0000,  15'b01_0_0_0_0_0_1_0_1_0_0111};
    vecs[6]  = {9'b01010_0000,  15'b00_0_0_1_0_0_0_0_0_0_0111};
    vecs[7]  = {9'b01011_0000,  15'b00_0_0_0_0_0_0_0_0_1_1000};
    vecs[8]  = {9'b01100_0011,  15'b00_1_0_0_0_0_0_0_0_0_0000};
    vecs[9]  = {9'b00110_0000,  15'b00_0_0_0_0_0_1_0_0_0_0110};
    vecs[10] = {9'b01111_0000,  15'b00_0_0_0_0_0_0_0_0_0_0000};
    vecs[11] = {9'b11_000_0000, 15'b10_0_0_0_0_0_1_0_0_0_0000};

    mach_code  = 9'b01001_0000;
    one_flag   = 1'b0;
    reljump_en = 1'b0;
    reset      = 1'b0;

    // Reset held two cycles; decode keeps working while reset is low.
    step(9'b01001_0000, 1'b0, 1'b0, 1'b0);
    chk("mem_read_in_reset", 32'(MemRead), 32'd1);
    step(9'b00000_0000, 1'b0, 1'b0, 1'b0);
    chk("pc_after_reset", 32'(prog_ctr), 32'd0);
    chk("done_after_reset", 32'(done), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(9'b00000_0000, 1'b0, 1'b0, 1'b1);
      chk("pc_increment", 32'(prog_ctr), 32'(i));
    end

    // Branch taken to LUT[3].
    mach_code = 9'b01100_0011; one_flag = 1'b1; #1;
    chk("branch_inst", 32'(BranchInst), 32'd1);
    step(9'b01100_0011, 1'b1, 1'b0, 1'b1);
    chk("branch_taken", 32'(prog_ctr), 32'd48);

    // Branch not taken from PC 5.
    step(9'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(9'b0, 1'b0, 1'b0, 1'b1);
    step(9'b01100_0011, 1'b0, 1'b0, 1'b1);
    chk("branch_not_taken", 32'(prog_ctr), 32'd6);

    // Relative jump from PC 10, then absolute beats relative.
    step(9'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(9'b0, 1'b0, 1'b0, 1'b1);
    step(9'b00000_0010, 1'b0, 1'b1, 1'b1);
    chk("rel_jump", 32'(prog_ctr), 32'd42);
    step(9'b01100_0010, 1'b1, 1'b1, 1'b1);
    chk("abs_over_rel", 32'(prog_ctr), 32'd32);

    // Decode table sweep.
    for (int i = 0; i < 12; i++) begin
      mach_code = vecs[i].mc;
      #1;
      chk($sformatf("vec%0d", i), 32'(actual_ctrl()), 32'(vecs[i].exp));
    end

    // done at 65.
    step(9'b0, 1'b0, 1'b0, 1'b0);
    step(9'b01100_0100, 1'b1, 1'b0, 1'b1);
    chk("pc_64", 32'(prog_ctr), 32'd64);
    chk("done_at_64", 32'(done), 32'd0);
    step(9'b0, 1'b0, 1'b0, 1'b1);
    chk("done_at_65", 32'(done), 32'd1);
    step(9'b0, 1'b0, 1'b0, 1'b1);
    chk("done_at_66", 32'(done), 32'd0);

    // Wrap from 4095 to 0: 17 relative jumps of 240, then 15 increments.
    step(9'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) step(9'b00000_1111, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) step(9'b0, 1'b0, 1'b0, 1'b1);
    chk("pc_4095", 32'(prog_ctr), 32'd4095);
    step(9'b0, 1'b0, 1'b0, 1'b1);
    chk("pc_wrap", 32'(prog_ctr), 32'd0);

    // Randomized run against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(9'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 31) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
